// File: rtl/mem_load_unit_if.sv
// Load-unit bus bundle: request, data-memory read port and response handshake.
// slave is the load unit's view; master is the pipeline/memory side.
interface mem_load_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_op;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport slave (
    input  ld_valid, ld_addr, ld_op,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  rsp_ready,
    output ld_ready, mem_req, mem_addr,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output ld_valid, ld_addr, ld_op,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output rsp_ready,
    input  ld_ready, mem_req, mem_addr,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_load_unit.sv
// Sequential load path: aligned bus reads, byte shift-down, sign/zero extension.
// MEM_LOAD_MISALIGN_EN enables misaligned loads (two beats when crossing a bus word).
module mem_load_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_load_unit_if.slave   bus
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);

`ifdef MEM_LOAD_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

  state_t          state, state_d;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_load;
  logic            reject;
  logic [OB-1:0]   off_q;
  logic [XLEN-1:0] aligned;
`ifdef MEM_LOAD_MISALIGN_EN
  logic [XLEN-1:0] buf0;
  logic            buf0_load;
`endif

  function automatic logic illegal_op(input logic [2:0] op);
    return (op == 3'b111) || ((XLEN == 32) && ((op == 3'b011) || (op == 3'b110)));
  endfunction

  function automatic int unsigned nbytes(input logic [2:0] op);
    return 32'd1 << op[1:0];
  endfunction

  function automatic int unsigned offset(input logic [XLEN-1:0] a);
    return 32'(a[OB-1:0]);
  endfunction

`ifdef MEM_LOAD_MISALIGN_EN
  function automatic logic crossing(input logic [XLEN-1:0] a, input logic [2:0] op);
    return (offset(a) + nbytes(op)) > NB;
  endfunction
`else
  function automatic logic misaligned(input logic [XLEN-1:0] a, input logic [2:0] op);
    return (offset(a) & (nbytes(op) - 32'd1)) != 32'd0;
  endfunction
`endif

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] lo,
                                            input logic [XLEN-1:0] hi,
                                            input logic [OB-1:0]   off);
    return XLEN'({hi, lo} >> {off, 3'b000});
  endfunction

  // Left-justify the field, then shift back arithmetically or logically.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] s, input logic [2:0] op);
    int unsigned     bits, sh;
    logic [XLEN-1:0] t;
    bits = 8 * nbytes(op);
    sh   = (bits >= XLEN) ? 32'd0 : XLEN - bits;
    t    = s << sh;
    if (op[2]) t = t >> sh;
    else       t = $signed(t) >>> sh;
    return t;
  endfunction

  assign off_q   = addr_q[OB-1:0];
  assign aligned = {addr_q[XLEN-1:OB], {OB{1'b0}}};

`ifdef MEM_LOAD_MISALIGN_EN
  assign reject       = illegal_op(bus.ld_op);
  assign bus.mem_req  = (state == REQ0) || (state == REQ1);
  assign bus.mem_addr = (state == REQ1) ? aligned + XLEN'(NB) : aligned;
`else
  assign reject       = illegal_op(bus.ld_op) || misaligned(bus.ld_addr, bus.ld_op);
  assign bus.mem_req  = (state == REQ0);
  assign bus.mem_addr = aligned;
`endif

  assign bus.ld_ready  = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    state_d    = state;
    rsp_load   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
`ifdef MEM_LOAD_MISALIGN_EN
    buf0_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.ld_valid) begin
          if (reject) begin
            state_d   = RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = REQ0;
          end
        end
      end
      REQ0: if (bus.mem_gnt) state_d = WAIT0;
      WAIT0: begin
        if (bus.mem_rvalid) begin
          if (bus.mem_err) begin
            state_d   = RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end
`ifdef MEM_LOAD_MISALIGN_EN
          else if (crossing(addr_q, op_q)) begin
            state_d   = REQ1;
            buf0_load = 1'b1;
          end
`endif
          else begin
            state_d    = RESP;
            rsp_load   = 1'b1;
            rsp_data_d = extend(merge(bus.mem_rdata, '0, off_q), op_q);
          end
        end
      end
`ifdef MEM_LOAD_MISALIGN_EN
      REQ1: if (bus.mem_gnt) state_d = WAIT1;
      WAIT1: begin
        if (bus.mem_rvalid) begin
          state_d  = RESP;
          rsp_load = 1'b1;
          if (bus.mem_err) rsp_err_d = 1'b1;
          else             rsp_data_d = extend(merge(buf0, bus.mem_rdata, off_q), op_q);
        end
      end
`endif
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef MEM_LOAD_MISALIGN_EN
      buf0       <= '0;
`endif
    end else begin
      state <= state_d;
      if ((state == IDLE) && bus.ld_valid) begin
        addr_q <= bus.ld_addr;
        op_q   <= bus.ld_op;
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
`ifdef MEM_LOAD_MISALIGN_EN
      if (buf0_load) buf0 <= bus.mem_rdata;
`endif
    end
  end
endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit (XLEN=32): vector table, randomized loads against a
// byte-level reference model, and a reset-during-WAIT0 sequence.
module tb_mem_load_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_load_unit_if #(.XLEN(32)) bus();
  mem_load_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef MEM_LOAD_MISALIGN_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] b0, b1;
    bit          e0, e1;
    int          gw, rw, ry;
    logic [31:0] xd;
    bit          xe;
    int          xl, xn;
    logic [31:0] xa0, xa1;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: little-endian byte view of the two beats, assembled byte by byte.
  function automatic void model(input logic [31:0] addr, input logic [2:0] op,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input bit e0, input bit e1, input int gw, input int rw,
                                output logic [31:0] xd, output bit xe, output int xl,
                                output int xn, output logic [31:0] xa0, output logic [31:0] xa1);
    int          size, off;
    logic [7:0]  mem [8];
    logic [63:0] v;
    bit          bad;
    size = 1 << op[1:0];
    off  = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      mem[i]   = b0[8*i +: 8];
      mem[i+4] = b1[8*i +: 8];
    end
    xa0 = {addr[31:2], 2'b00};
    xa1 = xa0 + 32'd4;
    bad = (op == 3'b111) || (op == 3'b011) || (op == 3'b110) || (!EN && (off % size) != 0);
    xd = '0; xe = 1'b0; xn = 0; xl = 1;
    if (bad) begin xe = 1'b1; return; end
    xn = 1; xl = 3 + gw + rw;
    if (e0) begin xe = 1'b1; return; end
    if (off + size > 4) begin
      xn = 2; xl = 5 + 2*gw + 2*rw;
      if (e1) begin xe = 1'b1; return; end
    end
    v = '0;
    for (int i = 0; i < size; i++) v = v | (64'(mem[off+i]) << (8*i));
    if (!op[2] && v[8*size-1]) v = v | (~64'd0 << (8*size));
    xd = v[31:0];
  endfunction

  task automatic idle_inputs();
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_op = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  // Drives one request and plays memory + consumer; entered and left #1 after a posedge.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] op,
                          input logic [31:0] b0, input logic [31:0] b1, input bit e0, input bit e1,
                          input int gw, input int rw, input int ry, input bit junk,
                          output logic [31:0] data, output bit err, output int lat, output int nreq,
                          output logic [31:0] a0, output logic [31:0] a1,
                          output bit stable, output bit done);
    int gcnt, rv_at, hold;
    logic [31:0] cur_a;
    bit in_req;
    stable = 1'b1; nreq = 0; lat = -1; done = 1'b0; a0 = '0; a1 = '0; data = '0; err = 1'b0;
    hold = 0; gcnt = 0; rv_at = -1; in_req = 1'b0; cur_a = '0;
    bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_op = op;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.ld_addr = $urandom; bus.ld_op = 3'($urandom);
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
      bus.rsp_ready = 1'b0; bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (!in_req) begin
          in_req = 1'b1; gcnt = 0; cur_a = bus.mem_addr; nreq++;
          if (nreq == 1) a0 = cur_a; else a1 = cur_a;
        end else if (bus.mem_addr !== cur_a) stable = 1'b0;
        if (gcnt == gw) begin
          bus.mem_gnt = 1'b1; in_req = 1'b0; rv_at = cyc + 1 + rw;
        end else gcnt++;
        if (junk) begin bus.mem_rvalid = 1'b1; bus.mem_err = 1'($urandom_range(0, 1)); end
      end
      if (cyc == rv_at) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = (nreq == 1) ? b0 : b1;
        bus.mem_err    = (nreq == 1) ? e0 : e1;
        rv_at = -1;
      end
      if (bus.rsp_valid) begin
        if (hold == 0) begin lat = cyc; data = bus.rsp_data; err = bus.rsp_err; end
        else if (bus.rsp_data !== data || bus.rsp_err !== err) stable = 1'b0;
        if (junk) begin bus.mem_rvalid = 1'b1; bus.mem_err = 1'b1; end
        if (hold == ry) begin bus.rsp_ready = 1'b1; done = 1'b1; end
        hold++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic apply(input string tag, input logic [31:0] addr, input logic [2:0] op,
                       input logic [31:0] b0, input logic [31:0] b1, input bit e0, input bit e1,
                       input int gw, input int rw, input int ry, input bit junk,
                       input logic [31:0] xd, input bit xe, input int xl, input int xn,
                       input logic [31:0] xa0, input logic [31:0] xa1);
    logic [31:0] data, a0, a1;
    bit err, stable, done;
    int lat, nreq;
    run_load(addr, op, b0, b1, e0, e1, gw, rw, ry, junk, data, err, lat, nreq, a0, a1, stable, done);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " rsp_data"}, data, xd);
    chk({tag, " rsp_err"}, 32'(err), 32'(xe));
    chk({tag, " latency"}, lat, xl);
    chk({tag, " mem_req count"}, nreq, xn);
    if (xn >= 1) chk({tag, " mem_addr0"}, a0, xa0);
    if (xn == 2) chk({tag, " mem_addr1"}, a1, xa1);
    chk({tag, " held stable"}, 32'(stable), 32'd1);
    chk({tag, " ld_ready after"}, 32'(bus.ld_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " ld_ready"},  32'(bus.ld_ready),  32'd1);
    chk({tag, " mem_req"},   32'(bus.mem_req),   32'd0);
    chk({tag, " mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " rsp_data"},  bus.rsp_data,       32'd0);
    chk({tag, " rsp_err"},   32'(bus.rsp_err),   32'd0);
  endtask

  initial begin
    vec_t vq[$];
    vec_t v;
    logic [31:0] addr, b0, b1, xd, xa0, xa1;
    logic [2:0] op;
    bit e0, e1, xe, junk;
    int gw, rw, ry, xl, xn;

    //        addr          op      b0            b1            e0 e1 gw rw ry  xd            xe  xl xn xa0           xa1
    vq.push_back('{32'h0000_1003, 3'b000, 32'h80FF_1234, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h0000_1000, 32'h0});
    vq.push_back('{32'h0000_2002, 3'b101, 32'hBEEF_0000, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0000_BEEF, 1'b0, 3, 1, 32'h0000_2000, 32'h0});
    vq.push_back('{32'h0000_2000, 3'b010, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h1234_5678, 1'b0, 3, 1, 32'h0000_2000, 32'h0});
    vq.push_back('{32'h0000_4000, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 0, 0, 0, 32'h0,         1'b1, 3, 1, 32'h0000_4000, 32'h0});
    vq.push_back('{32'h0000_4000, 3'b111, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0,         1'b1, 1, 0, 32'h0,         32'h0});
    vq.push_back('{32'h0000_4000, 3'b011, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0,         1'b1, 1, 0, 32'h0,         32'h0});
    vq.push_back('{32'h0000_4000, 3'b110, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0,         1'b1, 1, 0, 32'h0,         32'h0});
    vq.push_back('{32'h0000_5001, 3'b100, 32'h0000_F700, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0000_00F7, 1'b0, 3, 1, 32'h0000_5000, 32'h0});
    vq.push_back('{32'h0000_5002, 3'b001, 32'h8001_0000, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'hFFFF_8001, 1'b0, 3, 1, 32'h0000_5000, 32'h0});
    vq.push_back('{32'h0000_6000, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 3, 0, 2, 32'hCAFE_F00D, 1'b0, 6, 1, 32'h0000_6000, 32'h0});
    vq.push_back('{32'h0000_8000, 3'b101, 32'h1234_FFFE, 32'h0, 1'b0, 1'b0, 0, 2, 0, 32'h0000_FFFE, 1'b0, 5, 1, 32'h0000_8000, 32'h0});
`ifdef MEM_LOAD_MISALIGN_EN
    vq.push_back('{32'h0000_3002, 3'b010, 32'hAAAA_1111, 32'h2222_BBBB, 1'b0, 1'b0, 0, 0, 0, 32'hBBBB_AAAA, 1'b0, 5, 2, 32'h0000_3000, 32'h0000_3004});
    vq.push_back('{32'hFFFF_FFFF, 3'b001, 32'hC300_0000, 32'h0000_00A5, 1'b0, 1'b0, 0, 0, 0, 32'hFFFF_A5C3, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0000_0000});
    vq.push_back('{32'h0000_7001, 3'b001, 32'h00AB_CD00, 32'h0,         1'b0, 1'b0, 0, 0, 0, 32'hFFFF_ABCD, 1'b0, 3, 1, 32'h0000_7000, 32'h0});
    vq.push_back('{32'h0000_4002, 3'b010, 32'h1234_5678, 32'h9999_9999, 1'b1, 1'b0, 0, 0, 0, 32'h0,         1'b1, 3, 1, 32'h0000_4000, 32'h0});
    vq.push_back('{32'h0000_9003, 3'b010, 32'h1234_5678, 32'h9999_9999, 1'b0, 1'b1, 1, 1, 1, 32'h0,         1'b1, 9, 2, 32'h0000_9000, 32'h0000_9004});
`else
    vq.push_back('{32'h0000_3002, 3'b010, 32'hAAAA_1111, 32'h2222_BBBB, 1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
    vq.push_back('{32'hFFFF_FFFF, 3'b001, 32'hC300_0000, 32'h0000_00A5, 1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
    vq.push_back('{32'h0000_7001, 3'b001, 32'h00AB_CD00, 32'h0,         1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
    vq.push_back('{32'h0000_4002, 3'b010, 32'h1234_5678, 32'h9999_9999, 1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
    vq.push_back('{32'h0000_9003, 3'b010, 32'h1234_5678, 32'h9999_9999, 1'b0, 1'b1, 1, 1, 1, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
`endif

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      v = vq[i];
      apply($sformatf("vec%0d", i), v.addr, v.op, v.b0, v.b1, v.e0, v.e1, v.gw, v.rw, v.ry, 1'b0,
            v.xd, v.xe, v.xl, v.xn, v.xa0, v.xa1);
    end

    for (int i = 0; i < 250; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : 32'($urandom);
      op   = 3'($urandom_range(0, 7));
      b0   = $urandom; b1 = $urandom;
      e0   = ($urandom_range(0, 7) == 0);
      e1   = ($urandom_range(0, 7) == 0);
      gw   = $urandom_range(0, 2); rw = $urandom_range(0, 2); ry = $urandom_range(0, 2);
      junk = 1'($urandom_range(0, 1));
      model(addr, op, b0, b1, e0, e1, gw, rw, xd, xe, xl, xn, xa0, xa1);
      apply($sformatf("rnd%0d", i), addr, op, b0, b1, e0, e1, gw, rw, ry, junk, xd, xe, xl, xn, xa0, xa1);
    end

    // Reset while a read is outstanding, then a stale rvalid for that read.
    apply("pre_rst", 32'h0000_2000, 3'b010, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0,
          32'h1234_5678, 1'b0, 3, 1, 32'h0000_2000, 32'h0);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h0000_1230; bus.ld_op = 3'b010;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    chk("abort mem_req", 32'(bus.mem_req), 32'd1);
    chk("abort mem_addr", bus.mem_addr, 32'h0000_1230);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    chk("abort in WAIT0 mem_req", 32'(bus.mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stale rvalid rsp_valid %0d", i), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("stale rvalid ld_ready %0d", i), 32'(bus.ld_ready), 32'd1);
      @(posedge clk); #1;
    end
    apply("post_rst", 32'h0000_1003, 3'b000, 32'h80FF_1234, 32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0,
          32'hFFFF_FF80, 1'b0, 3, 1, 32'h0000_1000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Parametrised load path that replaces the purely combinational load extender. It accepts a load request (address plus op), issues one or two aligned reads on the data-memory port, shifts the addressed bytes down, and sign- or zero-extends them to XLEN. The result is returned over a valid/ready handshake. The block sits between the MEM stage and the data-memory interface, with one outstanding load at a time.

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64; memory bus width equals XLEN.
- NB, default XLEN/8: bytes per bus word (derived; not overridden).
- OB, default log2(NB): byte-offset bits (derived).
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ld_valid  input  1  load request valid.
- ld_ready  output  1  block can accept a request; high only in IDLE.
- ld_addr  input  XLEN  byte address.
- ld_op  input  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- mem_req  output  1  read request to memory.
- mem_addr  output  XLEN  word-aligned read address (low OB bits zero).
- mem_gnt  input  1  memory accepted mem_req this cycle.
- mem_rvalid  input  1  read data valid; earliest one cycle after mem_gnt.
- mem_rdata  input  XLEN  read data.
- mem_err  input  1  bus error; qualified by mem_rvalid.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  XLEN  extended load result.
- rsp_err  output  1  load faulted; rsp_data is 0 when set.

## Operation
- Size: B=1, H=2, W=4, D=8 bytes. off = ld_addr[OB-1:0]. Aligned when off mod size == 0. Crossing when off+size > NB.
- Illegal op: 111; D or WU when XLEN=32. An illegal op goes straight to RESP with rsp_err=1 and no memory access.
- States:
  - IDLE: on accept, latch addr, op and off. Illegal op goes to RESP with error. Otherwise go to REQ0.
  - REQ0: mem_req=1, mem_addr = addr with low OB bits cleared. On mem_gnt go to WAIT0.
  - WAIT0: on mem_rvalid, store the beat in buf0. If mem_err, go to RESP with error. If crossing, go to REQ1. Otherwise go to RESP.
  - REQ1: mem_req=1, mem_addr = aligned addr + NB, modulo 2^XLEN (wraps at the top of the address space). On mem_gnt go to WAIT1.
  - WAIT1: on mem_rvalid, store the beat in buf1 and go to RESP. mem_err gives an error.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE.
- Merge: take the low XLEN bits of {buf1, buf0} >> (8*off). buf1 is zero when the access is not crossing. Keep the low size*8 bits. Sign-extend for B/H/W/D (D when XLEN=64 is a plain copy); zero-extend for BU/HU/WU.
- rsp_data and rsp_err are registered and stable while rsp_valid is high.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- mem_req and mem_addr are held stable until mem_gnt.
- Reset, including mid-operation: state returns to IDLE. Outputs: ld_ready=1, mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0. A late rvalid from a pre-reset read is ignored.

## Timing
- ld_ready is a function of state only; ld_valid has no combinational path to any output.
- Aligned or non-crossing load, with mem_gnt in the first REQ cycle and rvalid one cycle later:
  - accept at cycle 0
  - mem_req at cycle 1
  - rvalid at cycle 2
  - rsp_valid at cycle 3
- Crossing load: second mem_req at cycle 3, rvalid at cycle 4, rsp_valid at cycle 5.
- Illegal op: rsp_valid in the cycle after accept.
- Memory stalls (mem_gnt low, or rvalid delayed) extend the matching state one cycle at a time.
- Back-to-back: rsp_ready at cycle N returns to IDLE at N+1; the next accept is at N+1 at the earliest.

## Configuration
- MEM_LOAD_MISALIGN_EN defined: misaligned loads are supported. Non-crossing loads use one access; crossing loads use two.
- Not defined: any misaligned load (off mod size != 0), crossing or not, goes IDLE to RESP with rsp_err=1 and no memory access. REQ1/WAIT1 and buf1 are removed.

## Test plan
- XLEN=32, LB at 0x1003, rdata 0x80FF_1234 -> mem_addr 0x1000, rsp_data 0xFFFF_FF80, rsp_err 0, rsp_valid at cycle 3.
- LHU at 0x2002, rdata 0xBEEF_0000 -> rsp_data 0x0000_BEEF. LW at 0x2000, rdata 0x1234_5678 -> 0x1234_5678.
- With MEM_LOAD_MISALIGN_EN, LW at 0x3002, beats 0xAAAA_1111 then 0x2222_BBBB -> reads 0x3000 then 0x3004, rsp_data 0xBBBB_AAAA at cycle 5. Without the macro -> rsp_err 1, no mem_req.
- Crossing LH at 0xFFFF_FFFF -> second mem_addr wraps to 0x0000_0000.
- Error and illegal cases:
  - mem_err on the first beat -> rsp_err 1, rsp_data 0, no second request.
  - op 111 -> error with no mem_req.
  - XLEN=32 op 011 -> error.
- Stall and reset:
  - mem_gnt low for 3 cycles, then rsp_ready low for 2 cycles -> mem_addr and rsp_data held stable.
  - rst_n asserted in WAIT0 -> IDLE and all outputs at reset values; the stale rvalid that follows is ignored.
